// File: rtl/decodificador_4b5b_pkg.sv
// Shared 4B/5B code definitions, FSM state encoding and decoder payload type.
package decodificador_4b5b_pkg;

    localparam int unsigned CODE_W = 5;
    localparam int unsigned NIB_W  = 4;
    localparam int unsigned BYTE_W = 8;

    // 5-bit line codes for nibbles 0..F, common with the encoder
    localparam logic [CODE_W-1:0] CODE_0 = 5'b11110;
    localparam logic [CODE_W-1:0] CODE_1 = 5'b01001;
    localparam logic [CODE_W-1:0] CODE_2 = 5'b10100;
    localparam logic [CODE_W-1:0] CODE_3 = 5'b10101;
    localparam logic [CODE_W-1:0] CODE_4 = 5'b01010;
    localparam logic [CODE_W-1:0] CODE_5 = 5'b01011;
    localparam logic [CODE_W-1:0] CODE_6 = 5'b01110;
    localparam logic [CODE_W-1:0] CODE_7 = 5'b01111;
    localparam logic [CODE_W-1:0] CODE_8 = 5'b10010;
    localparam logic [CODE_W-1:0] CODE_9 = 5'b10011;
    localparam logic [CODE_W-1:0] CODE_A = 5'b10110;
    localparam logic [CODE_W-1:0] CODE_B = 5'b10111;
    localparam logic [CODE_W-1:0] CODE_C = 5'b11010;
    localparam logic [CODE_W-1:0] CODE_D = 5'b11011;
    localparam logic [CODE_W-1:0] CODE_E = 5'b11100;
    localparam logic [CODE_W-1:0] CODE_F = 5'b11101;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_HALF  = 2'd1,
        S_FULL  = 2'd2,
        S_FULLH = 2'd3
    } state_t;

    typedef struct packed {
        logic [NIB_W-1:0] nib;
        logic             valid;
    } dec_t;

endpackage

// File: rtl/decodificador_4b5b_dec.sv
// Combinational 5B -> 4B lookup; flags words outside the code table.
module dec4b5b
    import decodificador_4b5b_pkg::*;
(
    input  logic [CODE_W-1:0] code,
    output dec_t              dec_c
);

    always_comb begin
        dec_c.nib   = '0;
        dec_c.valid = 1'b1;
        case (code)
            CODE_0:  dec_c.nib = 4'h0;
            CODE_1:  dec_c.nib = 4'h1;
            CODE_2:  dec_c.nib = 4'h2;
            CODE_3:  dec_c.nib = 4'h3;
            CODE_4:  dec_c.nib = 4'h4;
            CODE_5:  dec_c.nib = 4'h5;
            CODE_6:  dec_c.nib = 4'h6;
            CODE_7:  dec_c.nib = 4'h7;
            CODE_8:  dec_c.nib = 4'h8;
            CODE_9:  dec_c.nib = 4'h9;
            CODE_A:  dec_c.nib = 4'hA;
            CODE_B:  dec_c.nib = 4'hB;
            CODE_C:  dec_c.nib = 4'hC;
            CODE_D:  dec_c.nib = 4'hD;
            CODE_E:  dec_c.nib = 4'hE;
            CODE_F:  dec_c.nib = 4'hF;
            default: dec_c.valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/decodificador_4b5b.sv
// 4B/5B decoder: pairs decoded nibbles into bytes with valid/ack handshake,
// one spare nibble of buffering, invalid-code counting and sticky overrun.
module decodificador_4b5b
    import decodificador_4b5b_pkg::*;
#(
    parameter int unsigned ERR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m1,
    input  logic              m2,
    input  logic              m3,
    input  logic              m4,
    input  logic              m5,
    input  logic              ready,
    output logic [BYTE_W-1:0] data_out,
    output logic              out_valid,
    input  logic              out_ack,
    output logic              code_err,
    output logic [ERR_W-1:0]  err_cnt,
    output logic              overrun
);

    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    state_t            state, state_n;
    logic [NIB_W-1:0]  hi_nib, hi_nib_n;
    logic [BYTE_W-1:0] data_n;
    logic [ERR_W-1:0]  err_cnt_n;
    logic              overrun_n;
    logic              word_ok, word_bad, ack;
    dec_t              dec;

    dec4b5b u_dec (
        .code  ({m1, m2, m3, m4, m5}),
        .dec_c (dec)
    );

    assign word_ok  = ready &  dec.valid;
    assign word_bad = ready & ~dec.valid;
    assign ack      = out_valid & out_ack;

    // Next-state and next-register values
    always_comb begin
        state_n   = state;
        hi_nib_n  = hi_nib;
        data_n    = data_out;
        overrun_n = overrun;
        err_cnt_n = err_cnt;

        if (word_bad && (err_cnt != ERR_MAX))
            err_cnt_n = err_cnt + ERR_W'(1);

        case (state)
            S_IDLE: begin
                if (word_ok) begin
                    state_n  = S_HALF;
                    hi_nib_n = dec.nib;
                end
            end
            S_HALF: begin
                if (word_ok) begin
                    state_n = S_FULL;
                    data_n  = {hi_nib, dec.nib};
                end else if (word_bad) begin
                    state_n = S_IDLE;
                end
            end
            S_FULL: begin
                if (ack) begin
                    if (word_ok) begin
                        state_n  = S_HALF;
                        hi_nib_n = dec.nib;
                    end else begin
                        state_n = S_IDLE;
                    end
                end else if (word_ok) begin
                    state_n  = S_FULLH;
                    hi_nib_n = dec.nib;
                end
            end
            S_FULLH: begin
                if (ack) begin
                    if (word_ok) begin
                        state_n = S_FULL;
                        data_n  = {hi_nib, dec.nib};
                    end else if (word_bad) begin
                        state_n = S_IDLE;
                    end else begin
                        state_n = S_HALF;
                    end
                end else if (word_ok) begin
                    overrun_n = 1'b1;
                end else if (word_bad) begin
                    // resync: drop the held high nibble, keep the pending byte
                    state_n = S_FULL;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            hi_nib    <= '0;
            data_out  <= '0;
            out_valid <= 1'b0;
            code_err  <= 1'b0;
            err_cnt   <= '0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_n;
            hi_nib    <= hi_nib_n;
            data_out  <= data_n;
            out_valid <= (state_n == S_FULL) || (state_n == S_FULLH);
            code_err  <= word_bad;
            err_cnt   <= err_cnt_n;
            overrun   <= overrun_n;
        end
    end

endmodule

// File: tb/tb_decodificador_4b5b.sv
// Directed self-checking bench for decodificador_4b5b.
module tb_decodificador_4b5b;

    logic       clk = 1'b0;
    logic       reset;
    logic       m1, m2, m3, m4, m5;
    logic       ready;
    logic [7:0] data_out;
    logic       out_valid;
    logic       out_ack;
    logic       code_err;
    logic [3:0] err_cnt;
    logic       overrun;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    decodificador_4b5b #(.ERR_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .m1        (m1),
        .m2        (m2),
        .m3        (m3),
        .m4        (m4),
        .m5        (m5),
        .ready     (ready),
        .data_out  (data_out),
        .out_valid (out_valid),
        .out_ack   (out_ack),
        .code_err  (code_err),
        .err_cnt   (err_cnt),
        .overrun   (overrun)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one word (optionally with ack) for one clock; returns at the next negedge.
    task automatic send(input logic [4:0] code, input logic ack);
        {m1, m2, m3, m4, m5} = code;
        ready   = 1'b1;
        out_ack = ack;
        @(negedge clk);
        ready   = 1'b0;
        out_ack = 1'b0;
        {m1, m2, m3, m4, m5} = 5'b00000;
    endtask

    task automatic ack_only();
        out_ack = 1'b1;
        @(negedge clk);
        out_ack = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        idle(n);
        reset = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        ready   = 1'b0;
        out_ack = 1'b0;
        {m1, m2, m3, m4, m5} = 5'b00000;
        @(negedge clk);

        // 1: reset values
        do_reset(2);
        check("rst_data", 32'(data_out), 32'h00);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_code_err", 32'(code_err), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);

        // 2: 0,1 -> 8'h01, valid right after 2nd capture, dropped by ack
        send(5'b11110, 1'b0);
        check("t2_valid_half", 32'(out_valid), 32'd0);
        send(5'b01001, 1'b0);
        check("t2_valid", 32'(out_valid), 32'd1);
        check("t2_data", 32'(data_out), 32'h01);
        ack_only();
        check("t2_valid_after_ack", 32'(out_valid), 32'd0);
        // ack while not valid is ignored
        ack_only();
        check("t2_stray_ack", 32'(out_valid), 32'd0);

        // 3: invalid word between 2 and 4 discards the 2
        send(5'b10100, 1'b0);
        send(5'b00000, 1'b0);
        check("t3_code_err", 32'(code_err), 32'd1);
        check("t3_err_cnt", 32'(err_cnt), 32'd1);
        idle(1);
        check("t3_code_err_pulse", 32'(code_err), 32'd0);
        // ready=0 with a valid pattern on m lines must be ignored
        {m1, m2, m3, m4, m5} = 5'b01111;
        idle(1);
        send(5'b01010, 1'b0);
        check("t3_valid_half", 32'(out_valid), 32'd0);
        send(5'b01011, 1'b0);
        check("t3_valid", 32'(out_valid), 32'd1);
        check("t3_data", 32'(data_out), 32'h45);
        ack_only();

        // 4: A,B then C held, D dropped -> overrun; ack leaves C as high nibble
        send(5'b10110, 1'b0);
        send(5'b10111, 1'b0);
        check("t4_data_ab", 32'(data_out), 32'hAB);
        send(5'b11010, 1'b0);
        check("t4_valid_fullh", 32'(out_valid), 32'd1);
        check("t4_overrun0", 32'(overrun), 32'd0);
        send(5'b11011, 1'b0);
        check("t4_overrun1", 32'(overrun), 32'd1);
        check("t4_data_hold", 32'(data_out), 32'hAB);
        ack_only();
        check("t4_valid_half", 32'(out_valid), 32'd0);
        send(5'b11100, 1'b0);
        check("t4_valid_ce", 32'(out_valid), 32'd1);
        check("t4_data_ce", 32'(data_out), 32'hCE);
        check("t4_overrun_sticky", 32'(overrun), 32'd1);
        ack_only();

        // 5: FULLH with D and ack together -> CD, no overrun
        do_reset(1);
        send(5'b10110, 1'b0);
        send(5'b10111, 1'b0);
        send(5'b11010, 1'b0);
        send(5'b11011, 1'b1);
        check("t5_valid", 32'(out_valid), 32'd1);
        check("t5_data", 32'(data_out), 32'hCD);
        check("t5_overrun", 32'(overrun), 32'd0);
        ack_only();
        check("t5_valid_ack", 32'(out_valid), 32'd0);

        // FULLH + invalid word: byte kept, held nibble dropped
        send(5'b10010, 1'b0);
        send(5'b10011, 1'b0);
        send(5'b11101, 1'b0);
        send(5'b00001, 1'b0);
        check("t5b_valid", 32'(out_valid), 32'd1);
        check("t5b_data", 32'(data_out), 32'h89);
        ack_only();
        check("t5b_idle", 32'(out_valid), 32'd0);

        // 6: saturation after 17 invalid words, then reset from HALF
        do_reset(1);
        for (int i = 0; i < 17; i++) send(5'b11111, 1'b0);
        check("t6_err_sat", 32'(err_cnt), 32'd15);
        send(5'b01110, 1'b0);
        check("t6_half_valid", 32'(out_valid), 32'd0);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        check("t6_rst_err_cnt", 32'(err_cnt), 32'd0);
        check("t6_rst_valid", 32'(out_valid), 32'd0);
        check("t6_rst_data", 32'(data_out), 32'h00);
        send(5'b10101, 1'b0);
        check("t6_idle_first", 32'(out_valid), 32'd0);
        send(5'b01111, 1'b0);
        check("t6_byte", 32'(data_out), 32'h37);
        check("t6_byte_valid", 32'(out_valid), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
